fxp_mul_arb: RTL
================

Name: fxp_mul_arb

Overview:
- Shares one pipelined signed Q16.16 multiplier among N_REQ requesters: EMA update, W1/W2 signal weighting and risk-limit scaling units.
- Round-robin arbitration with one grant per cycle.
- Per-lane valid/ready request handshake; tagged pipeline returns each result to its originating lane.
- Sits between the signal/risk datapath units and the single multiplier resource.

Parameters:
- N_REQ, 4, number of requester lanes (2..8).
- MUL_LAT, 2, cycles from accepted request to rsp_valid (1..4).
- FRAC, 16, fractional bits of the Q format.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  N_REQ  lane i has an operand pair
- req_ready  out  N_REQ  lane i granted this cycle
- req_a  in  N_REQ*32  lane i operand A at [32i+31:32i], signed Q16.16
- req_b  in  N_REQ*32  lane i operand B, same packing
- rsp_valid  out  N_REQ  one-cycle result pulse for lane i
- rsp_data  out  N_REQ*32  lane i result, same packing
- busy  out  1  any pipeline stage holds a valid entry

Behaviour:
- Interface: one clock (clk); reset synchronous, active-high (rst).
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, busy=0, RR pointer=0, all stage valids=0.
- Arbitration:
  - req_ready is combinational from req_valid and the pointer. At most one bit is set per cycle.
  - The set bit is the first lane with req_valid=1, searching from pointer upward with wrap N_REQ-1 -> 0.
  - Transfer occurs when req_valid[i] && req_ready[i].
  - After a grant to lane i, pointer <= (i+1) mod N_REQ. With no grant, the pointer holds.
  - req_ready is 0 while rst=1.
- Requester rule: req_a, req_b and req_valid stay stable while valid && !ready. Dropping valid before grant is legal; the lane is simply skipped.
- Pipeline:
  - Stage 0 registers the full 64-bit signed product a*b, a lane tag and a valid bit.
  - Stages 1..MUL_LAT-1 shift tag/valid/data forward.
  - The final stage drives outputs.
  - Throughput is 1 result/cycle; no stalls and no backpressure. Consumers must accept rsp_valid when it pulses.
- Latency: request accepted at edge t gives rsp_valid[i]=1 for exactly the cycle after edge t+MUL_LAT-1, i.e. MUL_LAT cycles after acceptance.
- rsp_data: the lane is written only on its pulse and holds its last value otherwise. At most one rsp_valid bit is set per cycle.
- Arithmetic:
  - result = product >>> FRAC (arithmetic shift; floor toward -inf), taking bits [31:0] of the shifted value.
  - Default build wraps on overflow.
  - -1 LSB * 1 LSB = 0xFFFFFFFF.
- busy = OR of all stage valid bits.
- Reset mid-operation: in-flight entries are discarded and no rsp_valid is issued for them. The pointer returns to 0, and the first grant after reset goes to the lowest requesting lane.
- A lane holding valid continuously with all lanes requesting gets a grant at least every N_REQ cycles (starvation bound).

Optional Feature:
- Macro: FXP_MUL_SAT_EN.
- Defined:
  - If the shifted 64-bit value exceeds 0x000000007FFFFFFF, result = 0x7FFFFFFF.
  - If it is below 0xFFFFFFFF80000000, result = 0x80000000.
  - Saturation is applied in the final stage; latency is unchanged.
- Undefined: plain truncation to 32 bits, wrap-around.

Test Plan:
- Lane 0 only: A=0x00018000 (1.5), B=0x00020000 (2.0) -> rsp_valid[0] MUL_LAT cycles later, rsp_data lane0=0x00030000.
- Lane 2: A=0xFFFF4000 (-0.75), B=0x00008000 (0.5) -> 0xFFFFA000 (-0.375). Also A=0xFFFFFFFF, B=0x00000001 -> 0xFFFFFFFF.
- All 4 lanes hold req_valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one req_ready bit per cycle. Responses return in the same order, one per cycle, each with correct data.
- Overflow: A=0x7FFF0000, B=0x00020000 -> 0xFFFE0000 without FXP_MUL_SAT_EN; 0x7FFFFFFF with it. A=0x80000000, B=0x00020000 -> 0x80000000 with saturation.
- Pointer at lane 3 with only lanes 1 and 3 requesting -> grant order 3,1,3,1. Lane 1 dropping valid before grant -> never granted, no response.
- Three requests in flight, rst asserted for one cycle -> no rsp_valid after reset, busy=0 next cycle, pointer=0. A request on lane 1 after reset is granted in its first cycle.

Source files
------------

// File: rtl/fxp_mul_arb.sv
// Round-robin arbiter sharing one pipelined signed Q16.16 multiplier among N_REQ lanes.
// Optional saturation of the final result is enabled by defining FXP_MUL_SAT_EN.
module fxp_mul_arb #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned FRAC    = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*32-1:0] req_a,
    input  logic [N_REQ*32-1:0] req_b,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [N_REQ*32-1:0] rsp_data,
    output logic                busy
);
    localparam int unsigned TagW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [TagW-1:0]              ptr_q, ptr_d;
    logic                         gnt_any;
    logic [TagW-1:0]              gnt_idx;
    int unsigned                  idx;
    logic [31:0]                  a_sel, b_sel;
    logic signed [63:0]           prod;
    logic [MUL_LAT-1:0]           stg_vld_q, stg_vld_d;
    logic [MUL_LAT-1:0][TagW-1:0] stg_tag_q, stg_tag_d;
    logic [MUL_LAT-1:0][63:0]     stg_prod_q, stg_prod_d;
    logic [N_REQ*32-1:0]          hold_q, hold_d;
    logic signed [63:0]           shifted;
    logic [31:0]                  result;
    logic                         unused_shift_hi;

    // First requesting lane at or above the pointer, wrapping; nothing is granted in reset.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        req_ready = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr_q) + k) % N_REQ;
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = TagW'(idx);
            end
        end
        if (rst) begin
            gnt_any = 1'b0;
        end
        req_ready[gnt_idx] = gnt_any;

        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (gnt_idx == TagW'(N_REQ - 1)) ? '0 : gnt_idx + TagW'(1);
        end
    end

    always_comb begin
        a_sel = req_a[32*gnt_idx +: 32];
        b_sel = req_b[32*gnt_idx +: 32];
        prod  = $signed({{32{a_sel[31]}}, a_sel}) * $signed({{32{b_sel[31]}}, b_sel});

        stg_vld_d     = stg_vld_q;
        stg_tag_d     = stg_tag_q;
        stg_prod_d    = stg_prod_q;
        stg_vld_d[0]  = gnt_any;
        stg_tag_d[0]  = gnt_idx;
        stg_prod_d[0] = prod;
        for (int unsigned i = 1; i < MUL_LAT; i++) begin
            stg_vld_d[i]  = stg_vld_q[i-1];
            stg_tag_d[i]  = stg_tag_q[i-1];
            stg_prod_d[i] = stg_prod_q[i-1];
        end
    end

    // Final stage: floor shift back to Q16.16, then wrap or saturate.
    always_comb begin
        shifted = $signed(stg_prod_q[MUL_LAT-1]) >>> FRAC;
        result  = shifted[31:0];
`ifdef FXP_MUL_SAT_EN
        unused_shift_hi = 1'b0;
        if (shifted > 64'sh0000_0000_7FFF_FFFF) begin
            result = 32'h7FFF_FFFF;
        end else if (shifted < 64'shFFFF_FFFF_8000_0000) begin
            result = 32'h8000_0000;
        end
`else
        unused_shift_hi = ^shifted[63:32];
`endif
    end

    // Each lane's data holds its last result between pulses.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = hold_q;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (stg_vld_q[MUL_LAT-1] && (stg_tag_q[MUL_LAT-1] == TagW'(i))) begin
                rsp_valid[i]         = 1'b1;
                rsp_data[32*i +: 32] = result;
            end
        end
        hold_d = rsp_data;
        busy   = |stg_vld_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q      <= '0;
            stg_vld_q  <= '0;
            stg_tag_q  <= '0;
            stg_prod_q <= '0;
            hold_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            stg_vld_q  <= stg_vld_d;
            stg_tag_q  <= stg_tag_d;
            stg_prod_q <= stg_prod_d;
            hold_q     <= hold_d;
        end
    end
endmodule
